// File: rtl/pll_bringup_seq.sv
// -----------------------------------------------------------------------------
// pll_bringup_seq
// Bring-up sequencer for a PLL loop. It walks the loop through a digital reset
// pulse, hands control from SPI to the loop, enables the PLL and fast AFC,
// pulses the loop reset again, waits for lock, opens an OTW calibration window
// and then parks in RUN. It watches for lock loss and services CONFIG reloads.
//
// Ports:
//   CLK, RST        clock (rising edge) and asynchronous active-high reset
//   START           begin bring-up from IDLE, or restart from ERROR
//   ABORT           return to IDLE next cycle from any state
//   CFG_REQ         CONFIG reload request, honoured only in RUN
//   LOCK            loop lock indicator, synchronous to CLK
//   SEQ_*           loop control outputs (registered)
//   BUSY/DONE/ERR   sequence status (registered)
//   STATE           current state code
// -----------------------------------------------------------------------------
module pll_bringup_seq #(
  parameter int unsigned T_RST    = 20,
  parameter int unsigned T_GAP    = 4,
  parameter int unsigned T_SETTLE = 2000,
  parameter int unsigned T_CAL    = 1300,
  parameter int unsigned T_CFG    = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       CFG_REQ,
  input  logic       LOCK,
  output logic       SEQ_NARST,
  output logic       SEQ_CTRL,
  output logic       SEQ_PLL_EN,
  output logic       SEQ_FAFC_EN,
  output logic       SEQ_CONFIG,
  output logic       SEQ_OTWCALI_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST1     = 4'd1,
    S_HANDOVER = 4'd2,
    S_ENABLE   = 4'd3,
    S_RST2     = 4'd4,
    S_SETTLE   = 4'd5,
    S_CAL      = 4'd6,
    S_RUN      = 4'd7,
    S_CFG      = 4'd8,
    S_ERROR    = 4'd9
  } state_e;

  typedef struct packed {
    logic narst;
    logic ctrl;
    logic pll_en;
    logic fafc_en;
    logic cfg_pulse;
    logic otwcali_en;
    logic busy;
    logic done;
    logic err;
  } outs_t;

  localparam outs_t IDLE_OUTS = '{narst: 1'b1, ctrl: 1'b1, default: 1'b0};

  // Output decode of a state; applied to the next state so that the registered
  // outputs line up with STATE in the same cycle.
  function automatic outs_t decode(state_e s);
    outs_t o;
    o = IDLE_OUTS;
    case (s)
      S_RST1:     begin o.narst = 1'b0; o.busy = 1'b1; end
      S_HANDOVER: begin o.ctrl = 1'b0; o.busy = 1'b1; end
      S_ENABLE, S_SETTLE: begin
        o.ctrl = 1'b0; o.pll_en = 1'b1; o.fafc_en = 1'b1; o.busy = 1'b1;
      end
      S_RST2: begin
        o.narst = 1'b0; o.ctrl = 1'b0; o.pll_en = 1'b1; o.fafc_en = 1'b1;
        o.busy = 1'b1;
      end
      S_CAL: begin
        o.ctrl = 1'b0; o.pll_en = 1'b1; o.fafc_en = 1'b1; o.otwcali_en = 1'b1;
        o.busy = 1'b1;
      end
      S_RUN: begin
        o.ctrl = 1'b0; o.pll_en = 1'b1; o.fafc_en = 1'b1; o.done = 1'b1;
      end
      S_CFG: begin
        o.ctrl = 1'b0; o.pll_en = 1'b1; o.fafc_en = 1'b1; o.cfg_pulse = 1'b1;
        o.busy = 1'b1; o.done = 1'b1;
      end
      S_ERROR: o.err = 1'b1;
      default: o = IDLE_OUTS;
    endcase
    return o;
  endfunction

  // Dwell counter reload value on entry; untimed states park it at zero.
  function automatic logic [15:0] load_val(state_e s);
    logic [15:0] v;
    v = 16'd0;
    case (s)
      S_RST1, S_RST2:       v = 16'(T_RST - 1);
      S_HANDOVER, S_ENABLE: v = 16'(T_GAP - 1);
      S_SETTLE:             v = 16'(T_SETTLE - 1);
      S_CAL:                v = 16'(T_CAL - 1);
      S_CFG:                v = 16'(T_CFG - 1);
      default:              v = 16'd0;
    endcase
    return v;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lock_run_q, lock_run_d;  // consecutive qualifying LOCK samples
  outs_t       outs_q;
  logic        expired;
  logic        lock_qual;

  assign expired = (cnt_q == 16'd0);

  // SETTLE qualifies on LOCK high, RUN on LOCK low (loss of lock).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statements can leave it unassigned and infer a latch.
    lock_qual = 1'b0;
    if (state_q == S_SETTLE) lock_qual = LOCK;
    else if (state_q == S_RUN) lock_qual = !LOCK;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (START)   state_d = S_RST1;
      S_RST1:     if (expired) state_d = S_HANDOVER;
      S_HANDOVER: if (expired) state_d = S_ENABLE;
      S_ENABLE:   if (expired) state_d = S_RST2;
      S_RST2:     if (expired) state_d = S_SETTLE;
      // A 4th qualifying sample beats a timeout landing in the same cycle.
      S_SETTLE: begin
        if (lock_qual && lock_run_q == 2'd3) state_d = S_CAL;
        else if (expired)                    state_d = S_ERROR;
      end
      S_CAL:      if (expired) state_d = S_RUN;
      // Lock loss beats a simultaneous CONFIG request.
      S_RUN: begin
        if (lock_qual && lock_run_q == 2'd3) state_d = S_ERROR;
        else if (CFG_REQ)                    state_d = S_CFG;
      end
      S_CFG:      if (expired) state_d = S_RUN;
      S_ERROR:    if (START)   state_d = S_RST1;
      default:                 state_d = S_IDLE;
    endcase
    if (ABORT) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d      = 16'd0;
    lock_run_d = 2'd0;
    if (state_d != state_q) begin
      cnt_d = load_val(state_d);
    end else begin
      cnt_d = expired ? 16'd0 : cnt_q - 16'd1;
      if (lock_qual && lock_run_q != 2'd3) lock_run_d = lock_run_q + 2'd1;
      else if (lock_qual)                  lock_run_d = lock_run_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      lock_run_q <= 2'd0;
      outs_q     <= IDLE_OUTS;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_run_q <= lock_run_d;
      outs_q     <= decode(state_d);
    end
  end

  assign SEQ_NARST      = outs_q.narst;
  assign SEQ_CTRL       = outs_q.ctrl;
  assign SEQ_PLL_EN     = outs_q.pll_en;
  assign SEQ_FAFC_EN    = outs_q.fafc_en;
  assign SEQ_CONFIG     = outs_q.cfg_pulse;
  assign SEQ_OTWCALI_EN = outs_q.otwcali_en;
  assign BUSY           = outs_q.busy;
  assign DONE           = outs_q.done;
  assign ERR            = outs_q.err;
  assign STATE          = state_q;

endmodule

// File: tb/tb_pll_bringup_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_bringup_seq
// Scoreboard bench for pll_bringup_seq with default parameters. Each scenario
// pushes expected output snapshots, tagged with the absolute clock edge they
// belong to, before driving its stimulus; a negedge monitor pops and compares
// them as the edges arrive.
// Snapshot layout: {STATE[3:0], NARST, CTRL, PLL_EN, FAFC_EN, CONFIG,
//                   OTWCALI_EN, BUSY, DONE, ERR}
// -----------------------------------------------------------------------------
module tb_pll_bringup_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cfg_req, lock;
  logic       seq_narst, seq_ctrl, seq_pll_en, seq_fafc_en, seq_config;
  logic       seq_otwcali_en, busy, done, err;
  logic [3:0] state;

  pll_bringup_seq dut (
    .CLK            (clk),
    .RST            (rst),
    .START          (start),
    .ABORT          (abort),
    .CFG_REQ        (cfg_req),
    .LOCK           (lock),
    .SEQ_NARST      (seq_narst),
    .SEQ_CTRL       (seq_ctrl),
    .SEQ_PLL_EN     (seq_pll_en),
    .SEQ_FAFC_EN    (seq_fafc_en),
    .SEQ_CONFIG     (seq_config),
    .SEQ_OTWCALI_EN (seq_otwcali_en),
    .BUSY           (busy),
    .DONE           (done),
    .ERR            (err),
    .STATE          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          cyc;
    logic [12:0] val;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, want, edge_cnt);
  endtask

  // Expected snapshot for a state code, taken from the per-state output table.
  function automatic logic [12:0] expv(input int st);
    logic [8:0] o;
    case (st)
      0:       o = 9'b110000_000;
      1:       o = 9'b010000_100;
      2:       o = 9'b100000_100;
      3:       o = 9'b101100_100;
      4:       o = 9'b001100_100;
      5:       o = 9'b101100_100;
      6:       o = 9'b101101_100;
      7:       o = 9'b101100_010;
      8:       o = 9'b101110_110;
      9:       o = 9'b110000_001;
      default: o = 9'b0;
    endcase
    return {4'(st), o};
  endfunction

  function automatic logic [12:0] observed();
    return {state, seq_narst, seq_ctrl, seq_pll_en, seq_fafc_en, seq_config,
            seq_otwcali_en, busy, done, err};
  endfunction

  task automatic push(input string tag, input int cyc, input int st);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc;
    e.val = expv(st);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= edge_cnt) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < edge_cnt) check({e.tag, "_missed"}, 32'(edge_cnt), 32'(e.cyc));
      else                  check(e.tag, 32'(observed()), 32'(e.val));
    end
  end

  // Returns at the negedge following absolute edge `target`.
  task automatic goto(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  // Drive START for one cycle from the current negedge; returns base edge b,
  // so the edge that samples START is b+1.
  task automatic pulse_start(output int b);
    b = edge_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_req = 1'b0; lock = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(observed()), 32'(expv(0)));
    rst = 1'b0;
    @(negedge clk);

    // Nominal bring-up with LOCK held high.
    lock = 1'b1;
    b = edge_cnt;
    push("rst1_first",  b + 1,    1);
    push("rst1_last",   b + 20,   1);
    push("handover",    b + 21,   2);
    push("handover_l",  b + 24,   2);
    push("enable",      b + 25,   3);
    push("enable_l",    b + 28,   3);
    push("rst2",        b + 29,   4);
    push("rst2_last",   b + 48,   4);
    push("settle",      b + 49,   5);
    push("settle_l",    b + 52,   5);
    push("cal_first",   b + 53,   6);
    push("cal_last",    b + 1352, 6);
    push("run_entry",   b + 1353, 7);
    push("run_hold",    b + 1360, 7);
    pulse_start(b);
    goto(b + 1361);

    // CONFIG reload from RUN: exactly T_CFG cycles, DONE held.
    b = edge_cnt;
    push("cfg_first", b + 1,  8);
    push("cfg_last",  b + 20, 8);
    push("cfg_back",  b + 21, 7);
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    goto(b + 22);

    // Three low LOCK samples are tolerated.
    b = edge_cnt;
    push("lock3_low", b + 3, 7);
    push("lock3_rec", b + 5, 7);
    lock = 1'b0;
    goto(b + 3);
    lock = 1'b1;
    goto(b + 6);

    // Four low samples -> ERROR, even with CFG_REQ on the 4th cycle.
    b = edge_cnt;
    push("lock4_pre", b + 3, 7);
    push("lock4_err", b + 4, 9);
    lock = 1'b0;
    goto(b + 3);
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    goto(b + 5);

    // Restart from ERROR with LOCK low -> settle timeout.
    b = edge_cnt;
    push("restart_rst1", b + 1,    1);
    push("to_settle",    b + 49,   5);
    push("to_settle_l",  b + 2048, 5);
    push("to_error",     b + 2049, 9);
    pulse_start(b);
    goto(b + 2050);

    // Restart with lock; CFG_REQ during CAL is ignored; RST during CAL.
    lock = 1'b1;
    b = edge_cnt;
    push("cal2_entry",   b + 53,  6);
    push("cal_cfg_ign",  b + 101, 6);
    push("cal_cfg_ign2", b + 125, 6);
    pulse_start(b);
    goto(b + 100);
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    goto(b + 200);
    #2 rst = 1'b1;
    #1 check("async_rst_cal", 32'(observed()), 32'(expv(0)));
    @(negedge clk);
    rst = 1'b0;
    b = edge_cnt;
    push("post_rst_idle",  b + 1, 0);
    push("post_rst_idle2", b + 4, 0);
    goto(b + 5);

    // ABORT with START in RST2 -> IDLE, START not honoured.
    b = edge_cnt;
    push("rst2_b",     b + 30, 4);
    push("abort_idle", b + 36, 0);
    push("abort_hold", b + 38, 0);
    pulse_start(b);
    goto(b + 35);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    goto(b + 39);

    @(negedge clk);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, "_unchecked"}, 32'(edge_cnt), 32'(e.cyc));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
